// File: rtl/player_mover_if.sv
// Bundle between the player mover, its button/level front end and the collision detector.
// Purely combinational wiring, no latency.
// No backpressure: the detector answers combinationally within the settle window.
interface player_mover_if;
    logic       btn_up;
    logic       btn_down;
    logic       btn_left;
    logic       btn_right;
    logic       level_load;
    logic [2:0] map_sel;
    logic [5:0] det_new_x;
    logic [5:0] det_new_y;
    logic [5:0] cur_x;
    logic [5:0] cur_y;
    logic [2:0] move;
    logic [2:0] map_out;
    logic       moved;
    logic       blocked;

    // The mover itself
    modport master (
        input  btn_up, btn_down, btn_left, btn_right, level_load, map_sel,
        input  det_new_x, det_new_y,
        output cur_x, cur_y, move, map_out, moved, blocked
    );

    // Environment: button front end plus collision detector
    modport slave (
        output btn_up, btn_down, btn_left, btn_right, level_load, map_sel,
        output det_new_x, det_new_y,
        input  cur_x, cur_y, move, map_out, moved, blocked
    );
endinterface

// File: rtl/player_mover.sv
// Owns the player grid position, issues one move to the collision detector and commits its answer.
// Latency: move code valid one edge after a press; result and moved/blocked pulse SETTLE_CYCLES edges later.
// No backpressure: held buttons are rate-limited by a HOLD_CYCLES cooldown, button changes during a request are ignored.
module player_mover #(
    parameter int START_X       = 1,
    parameter int START_Y       = 1,
    parameter int MAX_X         = 19,
    parameter int MAX_Y         = 14,
    parameter int SETTLE_CYCLES = 2,
    parameter int HOLD_CYCLES   = 12500000
) (
    input  logic            clk,
    input  logic            resetn,
    player_mover_if.master  pm
);
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_CYCLES - 1);
    localparam logic [5:0]    START_X_C   = 6'(START_X);
    localparam logic [5:0]    START_Y_C   = 6'(START_Y);
    localparam logic [5:0]    MAX_X_C     = 6'(MAX_X);
    localparam logic [5:0]    MAX_Y_C     = 6'(MAX_Y);

    typedef enum logic [1:0] {IDLE, REQ, COOL} state_t;

    state_t        r_state;
    logic [SW-1:0] r_settle;
    logic [HW-1:0] r_hold;
    logic [5:0]    r_cur_x;
    logic [5:0]    r_cur_y;
    logic [2:0]    r_move;
    logic [2:0]    r_map;
    logic          r_moved;
    logic          r_blocked;

    logic          w_any;
    logic [2:0]    w_code;
    logic          w_accept;
    logic          w_changed;

    assign w_any     = pm.btn_up | pm.btn_down | pm.btn_left | pm.btn_right;
    // Underflow below 0 shows up as 63 and fails this range check, so it reads as blocked.
    assign w_accept  = (pm.det_new_x <= MAX_X_C) && (pm.det_new_y <= MAX_Y_C);
    assign w_changed = w_accept && ((pm.det_new_x != r_cur_x) || (pm.det_new_y != r_cur_y));

    // Direction encode with priority up > down > left > right
    always_comb begin
        w_code = 3'b000;
        if (pm.btn_up)         w_code = 3'b001;
        else if (pm.btn_down)  w_code = 3'b011;
        else if (pm.btn_left)  w_code = 3'b010;
        else if (pm.btn_right) w_code = 3'b100;
    end

    // Control FSM: request, settle, commit, cooldown; level_load restarts and drops any in-flight commit
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= IDLE;
            r_settle  <= '0;
            r_hold    <= '0;
            r_cur_x   <= START_X_C;
            r_cur_y   <= START_Y_C;
            r_move    <= 3'b000;
            r_map     <= 3'b000;
            r_moved   <= 1'b0;
            r_blocked <= 1'b0;
        end else begin
            r_moved   <= 1'b0;
            r_blocked <= 1'b0;
            if (pm.level_load) begin
                r_state  <= IDLE;
                r_settle <= '0;
                r_hold   <= '0;
                r_cur_x  <= START_X_C;
                r_cur_y  <= START_Y_C;
                r_move   <= 3'b000;
                r_map    <= pm.map_sel;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_any) begin
                            r_move   <= w_code;
                            r_settle <= '0;
                            r_state  <= REQ;
                        end
                    end
                    REQ: begin
                        if (r_settle == SETTLE_LAST) begin
                            if (w_accept) begin
                                r_cur_x <= pm.det_new_x;
                                r_cur_y <= pm.det_new_y;
                            end
                            r_moved   <= w_changed;
                            r_blocked <= !w_changed;
                            r_move    <= 3'b000;
                            r_hold    <= '0;
                            r_state   <= COOL;
                        end else begin
                            r_settle <= r_settle + 1'b1;
                        end
                    end
                    COOL: begin
                        if (!w_any) begin
                            r_hold  <= '0;
                            r_state <= IDLE;
                        end else if (r_hold == HOLD_LAST) begin
                            r_move   <= w_code;
                            r_settle <= '0;
                            r_hold   <= '0;
                            r_state  <= REQ;
                        end else begin
                            r_hold <= r_hold + 1'b1;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign pm.cur_x   = r_cur_x;
    assign pm.cur_y   = r_cur_y;
    assign pm.move    = r_move;
    assign pm.map_out = r_map;
    assign pm.moved   = r_moved;
    assign pm.blocked = r_blocked;
endmodule
